bcd: RTL and testbench
======================

# bcd

Three-digit BCD up/down counter for the TM1638 display path. Four front-panel switches select the count direction, step size and clear. The block keeps a binary count modulo 1000 and presents it as three packed BCD digits, ready for the 7-segment encoder downstream.

## Interface
Parameters:
- TICK_DIV, default 1: number of clk cycles per count step; 1 means step every cycle.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- SWITCH1  input  1  count-up enable.
- SWITCH2  input  1  count-down enable.
- SWITCH3  input  1  step select: 0 = step 1, 1 = step 10.
- SWITCH4  input  1  synchronous clear, highest priority.
- dec_out  output  12  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds.

## Operation
- Internal state:
  - `cnt`, 10-bit binary, range 0..999.
  - Tick divider counting 0..TICK_DIV-1.
  - `dec_out` register.
- A tick is asserted when the divider equals TICK_DIV-1. The divider wraps to 0 on that cycle.
- Action on each tick, in priority order:
  - SWITCH4=1: cnt <= 0.
  - SWITCH1=1 and SWITCH2=0: cnt <= (cnt + step) mod 1000.
  - SWITCH2=1 and SWITCH1=0: cnt <= (cnt - step + 1000) mod 1000.
  - SWITCH1=SWITCH2 (both 0 or both 1): hold.
- step = 10 when SWITCH3=1, else 1.
- Wrap examples:
  - 999 +1 gives 000; 995 +10 gives 005.
  - 000 -1 gives 999; 003 -10 gives 993.
- Arithmetic is done in 11 bits, then reduced by one conditional subtract or add of 1000.
- Binary-to-BCD conversion is combinational double-dabble (shift-add-3) on `cnt`. Its result is registered into `dec_out`.
- Switches are sampled directly. Synchronising or debouncing them is the integrator's job.
- Every BCD digit of `dec_out` is always in 0..9.

## Timing
- Reset (rst=0, asynchronous):
  - cnt = 0, divider = 0, dec_out = 12'h000 immediately.
  - Applies mid-count as well; all progress is lost.
- On reset release, the first tick happens on the TICK_DIV-th rising edge.
- Latency: `dec_out` reflects `cnt` one clock after `cnt` updates. A switch change sampled at edge N therefore appears on `dec_out` after edge N+1 (TICK_DIV=1).
- SWITCH4 has no effect between ticks. With TICK_DIV=1 it acts every cycle.
- Switch changes between ticks have no effect. Only the value present at the tick edge matters.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_DIGITS = 3`
  - `CNT_MAX = 999`
  - typedef `bcd_digit_t` (logic [3:0])
  - typedef `bcd3_t` (logic [11:0])
- Sub-module `bin2bcd`: 10-bit binary in, `bcd3_t` out, purely combinational double-dabble. It is reused by other display blocks.
- Top `bcd` holds the divider, counter, control priority and output register.

## Test plan
Each line: stimulus -> required response.

1. Reset: hold rst=0 with random switches -> dec_out=000 continuously. Release with all switches 0 -> dec_out stays 000.
2. Count up: SWITCH1=1, TICK_DIV=1, from reset -> dec_out reads 001, 002, … on successive cycles, with one-cycle latency. After 20 cycles it reads 020 (BCD 12'h020, not 12'h014).
3. Decade step and wrap: SWITCH1=1, SWITCH3=1 from 990 -> 000, then 010. Then SWITCH3=0 from 999 -> 000.
4. Count down: SWITCH2=1 from 000 -> 999, 998. With SWITCH3=1 from 005 -> 995.
5. Conflict and clear:
   - SWITCH1=SWITCH2=1 -> value holds.
   - SWITCH4=1 with SWITCH1=1 at 437 -> 000 next tick.
   - Pulse rst low for 1 ns mid-count at 040 -> 000 immediately, and counting resumes from 000.
6. Divider: TICK_DIV=4, SWITCH1=1 -> count advances exactly once per 4 clocks. Toggling SWITCH1 between ticks has no effect.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the three-digit BCD display path.
// Other display blocks import the BCD types from here as well.
package bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int CNT_MAX    = 999;

    typedef logic [3:0]              bcd_digit_t;
    typedef logic [BCD_DIGITS*4-1:0] bcd3_t;

endpackage

// File: rtl/bcd_bin2bcd.sv
// Combinational double-dabble (shift-add-3) for a 10-bit binary value in 0..999.
// Produces three packed BCD digits: [3:0] ones, [7:4] tens, [11:8] hundreds.
module bin2bcd
    import bcd_pkg::*;
(
    input  logic [9:0] i_bin,
    output bcd3_t      o_bcd
);

    // Scratch register: BCD digits on top, binary shifted out of the bottom.
    logic [BCD_DIGITS*4+9:0] w_sr;

    always_comb begin
        w_sr = {{(BCD_DIGITS*4){1'b0}}, i_bin};
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (w_sr[10+4*d +: 4] >= 4'd5) begin
                    w_sr[10+4*d +: 4] = w_sr[10+4*d +: 4] + 4'd3;
                end
            end
            w_sr = w_sr << 1;
        end
    end

    assign o_bcd = w_sr[BCD_DIGITS*4+9:10];

endmodule

// File: rtl/bcd.sv
// Three-digit BCD up/down counter with a tick divider, switch-controlled
// direction/step/clear, and a registered packed-BCD output.
module bcd
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  SWITCH1,
    input  logic  SWITCH2,
    input  logic  SWITCH3,
    input  logic  SWITCH4,
    output bcd3_t dec_out
);

    localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [10:0]        CNT_MOD  = 11'(CNT_MAX + 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_cnt;

    logic             w_tick;
    logic [10:0]      w_step;
    logic [10:0]      w_sum;
    logic [10:0]      w_diff;
    logic [9:0]       w_up;
    logic [9:0]       w_dn;
    logic [9:0]       w_next;
    bcd3_t            w_bcd;

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_step = SWITCH3 ? 11'd10 : 11'd1;
        w_sum  = {1'b0, r_cnt} + w_step;
        w_diff = {1'b0, r_cnt} - w_step;
        w_up   = (w_sum >= CNT_MOD) ? 10'(w_sum - CNT_MOD) : w_sum[9:0];
        // A borrow leaves bit 10 set; adding the modulus back folds it into 0..999.
        w_dn   = w_diff[10] ? 10'(w_diff + CNT_MOD) : w_diff[9:0];

        w_next = r_cnt;
        if (SWITCH4) begin
            w_next = 10'd0;
        end else if (SWITCH1 && !SWITCH2) begin
            w_next = w_up;
        end else if (SWITCH2 && !SWITCH1) begin
            w_next = w_dn;
        end
    end

    bin2bcd u_bin2bcd (
        .i_bin (r_cnt),
        .o_bcd (w_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_cnt   <= 10'd0;
            dec_out <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_cnt <= w_next;
            end
            dec_out <= w_bcd;
        end
    end

endmodule

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: one instance stepping every clock, one every
// fourth clock, both driven by the same switches and checked against a model.
module tb_bcd;

    logic        clk;
    logic        rst;
    logic        sw1, sw2, sw3, sw4;
    logic [11:0] dec1, dec4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: index 0 is the TICK_DIV=1 instance, index 1 is TICK_DIV=4.
    int          m_cnt [2];
    int          m_cyc [2];
    logic [11:0] m_dec [2];
    int          m_div [2] = '{1, 4};

    bcd #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .SWITCH1(sw1), .SWITCH2(sw2),
        .SWITCH3(sw3), .SWITCH4(sw4), .dec_out(dec1)
    );

    bcd #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .SWITCH1(sw1), .SWITCH2(sw2),
        .SWITCH3(sw3), .SWITCH4(sw4), .dec_out(dec4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    function automatic int apply_step(input int c);
        int step;
        step = sw3 ? 10 : 1;
        if (sw4)              return 0;
        else if (sw1 && !sw2) return (c + step) % 1000;
        else if (sw2 && !sw1) return (c - step + 1000) % 1000;
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_cyc[k] = 0;
            m_dec[k] = 12'h000;
        end
    endtask

    // One rising edge; model sees the switch values present at the edge.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_cnt[k] = 0;
                m_cyc[k] = 0;
                m_dec[k] = 12'h000;
            end else begin
                m_dec[k] = to_bcd(m_cnt[k]);
                if (m_cyc[k] % m_div[k] == m_div[k] - 1) m_cnt[k] = apply_step(m_cnt[k]);
                m_cyc[k]++;
            end
        end
        #1;
    endtask

    task automatic set_sw(input logic a, input logic b, input logic c, input logic d);
        sw1 = a; sw2 = b; sw3 = c; sw4 = d;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dec1 !== 12'h000 || dec4 !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_pulse: dut1=%h dut4=%h required 000 000", dec1, dec4);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
            n_tests++;
            if (dec1 !== 12'h000 || dec4 !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold%0d: dut1=%h dut4=%h required 000 000", i, dec1, dec4);
            end
        end
        set_sw(0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_tests++;
            if (dec1 !== 12'h000 || dec4 !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_release%0d: dut1=%h dut4=%h required 000 000", i, dec1, dec4);
            end
        end
    endtask

    task automatic test_count_up();
        pulse_reset();
        set_sw(1, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin
            cycle();
            n_tests++;
            if (dec1 !== m_dec[0] || dec4 !== m_dec[1]) begin
                n_fail++;
                $display("FAIL count_up%0d: dut1=%h dut4=%h required %h %h",
                         i, dec1, dec4, m_dec[0], m_dec[1]);
            end
        end
        n_tests++;
        if (dec1 !== 12'h020) begin
            n_fail++;
            $display("FAIL count_up_20: dut1=%h required 020", dec1);
        end
    endtask

    task automatic test_decade_wrap();
        pulse_reset();
        set_sw(1, 0, 1, 0);
        for (int i = 0; i < 100; i++) cycle();
        n_tests++;
        if (dec1 !== 12'h990) begin
            n_fail++;
            $display("FAIL decade_990: dut1=%h required 990", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h000) begin
            n_fail++;
            $display("FAIL decade_wrap_000: dut1=%h required 000", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h010) begin
            n_fail++;
            $display("FAIL decade_wrap_010: dut1=%h required 010", dec1);
        end
        set_sw(0, 1, 0, 0);
        for (int i = 0; i < 21; i++) cycle();
        set_sw(1, 0, 0, 0);
        cycle();
        n_tests++;
        if (dec1 !== 12'h999) begin
            n_fail++;
            $display("FAIL unit_999: dut1=%h required 999", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h000 || dec4 !== m_dec[1]) begin
            n_fail++;
            $display("FAIL unit_wrap_000: dut1=%h dut4=%h required 000 %h", dec1, dec4, m_dec[1]);
        end
    endtask

    task automatic test_count_down();
        pulse_reset();
        set_sw(0, 1, 0, 0);
        cycle();
        cycle();
        n_tests++;
        if (dec1 !== 12'h999) begin
            n_fail++;
            $display("FAIL down_999: dut1=%h required 999", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h998) begin
            n_fail++;
            $display("FAIL down_998: dut1=%h required 998", dec1);
        end
        pulse_reset();
        set_sw(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        set_sw(0, 1, 1, 0);
        cycle();
        n_tests++;
        if (dec1 !== 12'h005) begin
            n_fail++;
            $display("FAIL down10_005: dut1=%h required 005", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h995 || dec4 !== m_dec[1]) begin
            n_fail++;
            $display("FAIL down10_995: dut1=%h dut4=%h required 995 %h", dec1, dec4, m_dec[1]);
        end
    endtask

    task automatic test_conflict_clear();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            set_sw(1, 1, 1'($urandom_range(0, 1)), 0);
            cycle();
            n_tests++;
            if (dec1 !== 12'h000 || dec4 !== 12'h000) begin
                n_fail++;
                $display("FAIL conflict_hold%0d: dut1=%h dut4=%h required 000 000", i, dec1, dec4);
            end
        end
        set_sw(1, 0, 1, 0);
        for (int i = 0; i < 43; i++) cycle();
        set_sw(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle();
        set_sw(1, 0, 0, 1);
        cycle();
        n_tests++;
        if (dec1 !== 12'h437) begin
            n_fail++;
            $display("FAIL clear_at_437: dut1=%h required 437", dec1);
        end
        cycle();
        n_tests++;
        if (dec1 !== 12'h000) begin
            n_fail++;
            $display("FAIL clear_000: dut1=%h required 000", dec1);
        end
        set_sw(1, 0, 0, 0);
        for (int i = 0; i < 41; i++) cycle();
        n_tests++;
        if (dec1 !== 12'h040) begin
            n_fail++;
            $display("FAIL mid_040: dut1=%h required 040", dec1);
        end
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (dec1 !== m_dec[0] || dec4 !== m_dec[1]) begin
                n_fail++;
                $display("FAIL resume%0d: dut1=%h dut4=%h required %h %h",
                         i, dec1, dec4, m_dec[0], m_dec[1]);
            end
        end
    endtask

    task automatic test_divider();
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            // Switch toggles land on non-tick cycles of the divided instance.
            if (m_cyc[1] % 4 == 3) set_sw(1, 0, 0, 0);
            else                   set_sw(1'($urandom_range(0, 1)), 0, 0, 0);
            cycle();
            n_tests++;
            if (dec4 !== m_dec[1] || dec1 !== m_dec[0]) begin
                n_fail++;
                $display("FAIL divider%0d: dut1=%h dut4=%h required %h %h",
                         i, dec1, dec4, m_dec[0], m_dec[1]);
            end
        end
        n_tests++;
        if (dec4 !== 12'h004) begin
            n_fail++;
            $display("FAIL divider_4_ticks: dut4=%h required 004", dec4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            cycle();
            n_tests++;
            if (dec1 !== m_dec[0] || dec4 !== m_dec[1]) begin
                n_fail++;
                $display("FAIL random%0d: dut1=%h dut4=%h required %h %h",
                         i, dec1, dec4, m_dec[0], m_dec[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_sw(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_count_up();
        test_decade_wrap();
        test_count_down();
        test_conflict_clear();
        test_divider();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
